// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared types and helpers for the stream demultiplexer
//
// Purpose: FSM state encoding and small elaboration-time helpers used by
//          stream_demux and demux_out_stage.
// Contents:
//   state_t      - IDLE (awaiting first beat), ROUTE (forwarding), DROP (discarding)
//   sel_in_range - true when a select value addresses an existing channel
//   sat_max      - all-ones value of a counter of the given width
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n_ch);
    return sel < n_ch;
  endfunction

  function automatic int unsigned sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/demux_out_stage.sv
// rtl/demux_out_stage.sv - single-entry output register with per-lane fan-out
//
// Purpose: holds one beat plus its destination and presents it on exactly one
//          output lane; reports whether a new beat can be taken this cycle.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   load                  - write load_* into the register this cycle
//   load_dest/data/last   - destination lane, payload and last flag of the beat
//   m_ready               - per-lane ready from downstream
//   ready                 - register is empty or drains this cycle
//   m_valid/m_data/m_last - per-lane outputs; idle lanes are driven to zero
module demux_out_stage
  import stream_demux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [SEL_W-1:0]         load_dest,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_last,
  input  logic [N_CH-1:0]          m_ready,
  output logic                     ready,
  output logic [N_CH-1:0]          m_valid,
  output logic [N_CH*DATA_W-1:0]   m_data,
  output logic [N_CH-1:0]          m_last
);

  logic              out_full;
  logic [SEL_W-1:0]  out_dest;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              sel_ready;

  // Only the ready of the lane currently holding the beat matters.
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (out_dest == SEL_W'(i)) sel_ready = m_ready[i];
    end
  end

  assign ready = !out_full || sel_ready;

  // Gate on out_full so a drained register leaves every lane at zero.
  always_comb begin
    m_valid = '0;
    m_data  = '0;
    m_last  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (out_full && out_dest == SEL_W'(i)) begin
        m_valid[i]                  = 1'b1;
        m_data[i*DATA_W +: DATA_W]  = out_data;
        m_last[i]                   = out_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_full <= 1'b0;
      out_dest <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (load) begin
      out_full <= 1'b1;
      out_dest <= load_dest;
      out_data <= load_data;
      out_last <= load_last;
    end else if (out_full && sel_ready) begin
      out_full <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-N packet stream demultiplexer
//
// Purpose: routes each packet of a valid/ready stream to one of N_CH channels,
//          selected on the first beat; packets to disabled or nonexistent
//          channels are swallowed and counted.
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last - upstream beat handshake and payload
//   s_sel, chan_en                - destination and channel enables (first beat only)
//   m_valid/m_ready/m_data/m_last - per-channel downstream streams
//   drop_err                      - one-cycle pulse per dropped packet
//   drop_cnt                      - saturating dropped-packet count
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  input  logic [SEL_W-1:0]         s_sel,
  input  logic [N_CH-1:0]          chan_en,
  output logic [N_CH-1:0]          m_valid,
  input  logic [N_CH-1:0]          m_ready,
  output logic [N_CH*DATA_W-1:0]   m_data,
  output logic [N_CH-1:0]          m_last,
  output logic                     drop_err,
  output logic [CNT_W-1:0]         drop_cnt
);

  generate
    if (N_CH < 2 || (2 ** SEL_W) < N_CH) begin : g_bad_params
      $error("stream_demux: need N_CH >= 2 and 2**SEL_W >= N_CH");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  state_t           state, next_state;
  logic [SEL_W-1:0] cur_dest;
  logic [SEL_W-1:0] load_dest;
  logic             chan_hit;
  logic             route_ok;
  logic             stage_ready;
  logic             load;
  logic             drop_now;
  logic             ready_c;

  // chan_en lookup by select; selects past N_CH never match and read as disabled.
  always_comb begin
    chan_hit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (s_sel == SEL_W'(i)) chan_hit = chan_en[i];
    end
  end

  assign route_ok = sel_in_range(32'(s_sel), N_CH) && chan_hit;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    drop_now   = 1'b0;
    ready_c    = 1'b0;
    case (state)
      IDLE: begin
        if (!route_ok) begin
          // A doomed packet never waits on downstream.
          ready_c = 1'b1;
          if (s_valid) begin
            drop_now = 1'b1;
            if (!s_last) next_state = DROP;
          end
        end else begin
          ready_c = stage_ready;
          if (s_valid && stage_ready) begin
            load = 1'b1;
            if (!s_last) next_state = ROUTE;
          end
        end
      end
      ROUTE: begin
        ready_c = stage_ready;
        if (s_valid && stage_ready) begin
          load = 1'b1;
          if (s_last) next_state = IDLE;
        end
      end
      DROP: begin
        ready_c = 1'b1;
        if (s_valid && s_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign s_ready   = rst_n && ready_c;
  assign load_dest = (state == IDLE) ? s_sel : cur_dest;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_dest <= '0;
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= next_state;
      drop_err <= drop_now;
      if (state == IDLE && load) cur_dest <= s_sel;
      if (drop_now && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  demux_out_stage #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_dest (load_dest),
    .load_data (s_data),
    .load_last (s_last),
    .m_ready   (m_ready),
    .ready     (stage_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last)
  );

endmodule
